add_n_parts: RTL

- Multi-cycle adder for wide field-arithmetic operands. It computes a + b in PARTS equal slices, one slice per clock, and propagates the carry between slices.
- It is the additive counterpart of the two-stage subtractor used in the EdDSA datapath.
- It feeds modular-reduction and point-arithmetic FSMs through a start/done handshake.

---
 rtl/add_n_parts_if.sv | 27 ++
 rtl/add_n_parts.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/add_n_parts_if.sv
// add_n_parts_if: start/done handshake and operand/result bus
// for the sliced multi-cycle adder.
interface add_n_parts_if #(
  parameter int SIZE = 448
);
  logic            start;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic [SIZE:0]   result;
  logic            done;

  modport master (
    output start,
    output a,
    output b,
    input  result,
    input  done
  );

  modport slave (
    input  start,
    input  a,
    input  b,
    output result,
    output done
  );
endinterface

// File: rtl/add_n_parts.sv
// add_n_parts: a + b over PARTS slices, one slice per clock.
// Option: ADD_N_PARTS_OPLATCH_EN latches a/b on the start edge.
module add_n_parts #(
  parameter int SIZE  = 448,
  parameter int PARTS = 4
) (
  input logic          clk,
  input logic          rst,
  add_n_parts_if.slave bus
);

  localparam int W  = SIZE / PARTS;
  localparam int IW = $clog2(PARTS);

  localparam logic [SIZE-1:0] SLICE_MASK =
    {{(SIZE-W){1'b0}}, {W{1'b1}}};

  localparam logic [IW-1:0] LAST_IDX = IW'(PARTS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            done_q, done_d;
  logic [SIZE:0]   result_q, result_d;
  logic            carry_q, carry_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [SIZE-1:0] sum_q, sum_d;

  logic [SIZE-1:0] src_a;
  logic [SIZE-1:0] src_b;
  logic [IW-1:0]   cur_idx;
  logic            cin;
  logic [31:0]     base;
  logic [SIZE-1:0] sh_a;
  logic [SIZE-1:0] sh_b;
  logic [W-1:0]    a_sl;
  logic [W-1:0]    b_sl;
  logic [W-1:0]    s_sl;
  logic            c_out;
  logic [SIZE-1:0] sum_ins;

`ifdef ADD_N_PARTS_OPLATCH_EN
  logic [SIZE-1:0] opa_q, opa_d;
  logic [SIZE-1:0] opb_q, opb_d;

  // Slice 0 reads the live bus; later slices read the latched copy.
  always_comb begin
    src_a = (state_q == IDLE) ? bus.a : opa_q;
    src_b = (state_q == IDLE) ? bus.b : opb_q;
  end

  // Operand capture on the accepting start edge.
  always_comb begin
    opa_d = opa_q;
    opb_d = opb_q;
    if (state_q == IDLE && bus.start) begin
      opa_d = bus.a;
      opb_d = bus.b;
    end
  end

  // Operand registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q <= '0;
      opb_q <= '0;
    end else begin
      opa_q <= opa_d;
      opb_q <= opb_d;
    end
  end
`else
  // Without latching, every slice reads the caller's operands.
  always_comb begin
    src_a = bus.a;
    src_b = bus.b;
  end
`endif

  // Slice select and W-bit add with carry from the previous slice.
  always_comb begin
    cur_idx = (state_q == IDLE) ? '0 : idx_q;
    cin     = (state_q == IDLE) ? 1'b0 : carry_q;
    base    = 32'(cur_idx) * 32'(W);
    sh_a    = src_a >> base;
    sh_b    = src_b >> base;
    a_sl    = sh_a[W-1:0];
    b_sl    = sh_b[W-1:0];
    {c_out, s_sl} = {1'b0, a_sl} + {1'b0, b_sl}
                  + {{W{1'b0}}, cin};
    sum_ins = (sum_q & ~(SLICE_MASK << base))
            | (SIZE'(s_sl) << base);
  end

  // Next-state and output logic of the slice sequencer.
  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    result_d = result_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    sum_d    = sum_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          sum_d   = sum_ins;
          carry_d = c_out;
          idx_d   = IW'(1);
          done_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d   = sum_ins;
        carry_d = c_out;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          result_d = {c_out, sum_ins};
          done_d   = 1'b1;
          idx_d    = '0;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      done_q   <= 1'b1;
      result_q <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      sum_q    <= '0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      sum_q    <= sum_d;
    end
  end

  assign bus.result = result_q;
  assign bus.done   = done_q;

endmodule
